// File: rtl/rv_pkg.sv
// Constants shared between the fetch stage and the decode stage.
package rv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry in-order buffer of {pc, instruction} between imem responses and decode.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_pc_i,
  input  logic [INSTR_W-1:0]           push_instr_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             head_pc_o,
  output logic [INSTR_W-1:0]           head_instr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flush wins over any push/pop in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      pc_mem_q[wr_ptr_q]    <= push_pc_i;
      instr_mem_q[wr_ptr_q] <= push_instr_i;
    end
  end

  assign head_pc_o    = pc_mem_q[rd_ptr_q];
  assign head_instr_o = instr_mem_q[rd_ptr_q];
  assign count_o      = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers
// in-order responses for decode and squashes wrong-path fetches on redirect.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WIDTH-1:0]   imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instruction,
  output logic [WIDTH-1:0]   id_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned USE_W = CNT_W + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   pc_q, pc_d, last_pc_q, last_pc_d;
  logic [CNT_W-1:0]   out_q, out_d, drop_q, drop_d, fifo_cnt;
  logic [WIDTH-1:0]   tag_q [DEPTH];
  logic [PTR_W-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [USE_W-1:0]   in_use;
  logic               pop, accept, push, fifo_pop;
  logic [WIDTH-1:0]   head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               unused_align;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign unused_align = ^redirect_pc[1:0];

  // Credit: an entry leaving for decode this cycle frees its slot for a new request.
  assign id_valid       = (fifo_cnt != '0);
  assign pop            = id_valid && id_ready;
  assign in_use         = USE_W'(out_q) + USE_W'(fifo_cnt) - USE_W'(pop);
  assign imem_req_valid = !rst && !redirect_valid && (in_use < USE_W'(DEPTH));
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc_q;
  assign push           = imem_resp_valid && (drop_q == '0) && !redirect_valid;
  assign fifo_pop       = pop && !redirect_valid;
  assign id_instruction = id_valid ? head_instr : NOP_INSTR;
  assign id_pc          = id_valid ? head_pc : last_pc_q;

  always_comb begin
    pc_d      = pc_q;
    drop_d    = drop_q;
    out_d     = out_q + CNT_W'(accept) - CNT_W'(imem_resp_valid);
    tag_wr_d  = accept ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d  = imem_resp_valid ? ptr_inc(tag_rd_q) : tag_rd_q;
    last_pc_d = id_valid ? head_pc : last_pc_q;
    if (redirect_valid) begin
      // Every request still in flight after this edge is wrong-path.
      pc_d   = {redirect_pc[WIDTH-1:2], 2'b00};
      drop_d = out_q - CNT_W'(imem_resp_valid);
    end else begin
      if (accept) pc_d = pc_q + WIDTH'(PC_INC);
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      last_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      last_pc_q <= last_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
    end
  end

  // PC tag of each outstanding request, consumed in response order.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr_q] <= pc_q;
  end

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_pc_i    (tag_q[tag_rd_q]),
    .push_instr_i (imem_resp_data),
    .pop_i        (fifo_pop),
    .flush_i      (redirect_valid),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (fifo_cnt)
  );

endmodule
